// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: MEM/WB bus layout, FSM encoding, stack pointer reset default.
package memory_stage_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned RDST_W     = 3;
  localparam int unsigned BUS_W      = 58;
  localparam int unsigned ADDR_W_DEF = 11;

  // MEM/WB bus bit positions, fixed by the writeback stage
  localparam int unsigned BIT_WB_EN     = 0;
  localparam int unsigned BIT_DBL       = 1;
  localparam int unsigned BIT_IN_SIG    = 2;
  localparam int unsigned BIT_POP       = 3;
  localparam int unsigned BIT_PUSH      = 4;
  localparam int unsigned BIT_MEM_WRITE = 5;
  localparam int unsigned BIT_MEM_READ  = 6;
  localparam int unsigned RDST_LSB      = 7;
  localparam int unsigned ALU_LSB       = 10;
  localparam int unsigned MEM_DATA_LSB  = 26;
  localparam int unsigned IN_PORT_LSB   = 42;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // Stack starts at the top word of the data memory
  function automatic int unsigned sp_init_default(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Data memory: 2^ADDR_W x 16, combinational read port, synchronous write port. Contents are not reset.
module memory_stage_data_memory
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: load/store, single and two-cycle double push/pop, stack pointer,
// and the registered 58-bit MEM/WB bus.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned SP_INIT = sp_init_default(ADDR_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   wdata_hi,
  input  logic [RDST_W-1:0]   rdst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                push,
  input  logic                pop,
  input  logic                dbl,
  input  logic                in_sig,
  input  logic                wb_en,
  input  logic [DATA_W-1:0]   in_port,
  input  logic                flush,
  output logic                stall,
  output logic [2*DATA_W-1:0] dbl_out,
  output logic [BUS_W-1:0]    out
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_sp;
  logic                r_dbl_pop;
  logic [DATA_W-1:0]   r_hi;
  logic [BUS_W-1:0]    r_out;
  logic [2*DATA_W-1:0] r_dbl_out;

  logic                w_idle;
  logic                w_op_push;
  logic                w_op_pop;
  logic                w_op_wr;
  logic                w_op_rd;
  logic                w_dbl_start;
  logic                w_stk_push;
  logic                w_stk_pop;
  logic                w_we;
  logic [ADDR_W-1:0]   w_alu_addr;
  logic [ADDR_W-1:0]   w_sp_inc;
  logic [ADDR_W-1:0]   w_sp_dec;
  logic [ADDR_W-1:0]   w_waddr;
  logic [ADDR_W-1:0]   w_raddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic [BUS_W-1:0]    w_bus;

  // Strobe priority: push > pop > mem_write > mem_read
  assign w_idle     = (r_state == ST_IDLE);
  assign w_op_push  = push;
  assign w_op_pop   = pop & ~push;
  assign w_op_wr    = mem_write & ~push & ~pop;
  assign w_op_rd    = mem_read & ~push & ~pop & ~mem_write;
  assign w_alu_addr = alu_res[ADDR_W-1:0];
  assign w_sp_inc   = r_sp + ADDR_W'(1);
  assign w_sp_dec   = r_sp - ADDR_W'(1);

  assign w_dbl_start = w_idle & ~flush & dbl & (push | pop);
  assign stall       = w_dbl_start;

  // In SECOND the op type comes from the latched flag; flush is ignored there
  assign w_stk_push = w_idle ? (~flush & w_op_push) : ~r_dbl_pop;
  assign w_stk_pop  = w_idle ? (~flush & w_op_pop)  :  r_dbl_pop;
  assign w_we       = w_stk_push | (w_idle & ~flush & w_op_wr);
  assign w_waddr    = w_stk_push ? r_sp : w_alu_addr;
  assign w_raddr    = w_stk_pop ? w_sp_inc : w_alu_addr;
  assign w_wdata    = (w_dbl_start & push) ? wdata_hi : wdata;

  memory_stage_data_memory #(
    .ADDR_W (ADDR_W)
  ) u_data_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Candidate MEM/WB bus for a completing (non-bubble) op
  always_comb begin
    w_bus = '0;
    w_bus[IN_PORT_LSB +: DATA_W] = in_port;
    w_bus[ALU_LSB +: DATA_W]     = alu_res;
    w_bus[RDST_LSB +: RDST_W]    = rdst;
    w_bus[BIT_IN_SIG]            = in_sig;
    w_bus[BIT_WB_EN]             = wb_en;
    if (w_idle) begin
      w_bus[BIT_MEM_READ]  = w_op_rd;
      w_bus[BIT_MEM_WRITE] = w_op_wr;
      w_bus[BIT_PUSH]      = w_op_push;
      w_bus[BIT_POP]       = w_op_pop;
      if (w_op_rd || w_op_pop) w_bus[MEM_DATA_LSB +: DATA_W] = w_rdata;
    end else begin
      w_bus[BIT_PUSH] = ~r_dbl_pop;
      w_bus[BIT_POP]  = r_dbl_pop;
      w_bus[BIT_DBL]  = 1'b1;
      if (r_dbl_pop) w_bus[MEM_DATA_LSB +: DATA_W] = w_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sp      <= ADDR_W'(SP_INIT);
      r_dbl_pop <= 1'b0;
      r_hi      <= '0;
      r_out     <= '0;
      r_dbl_out <= '0;
    end else begin
      if (w_stk_push)     r_sp <= w_sp_dec;
      else if (w_stk_pop) r_sp <= w_sp_inc;

      case (r_state)
        ST_IDLE: begin
          if (w_dbl_start) begin
            r_state   <= ST_SECOND;
            r_dbl_pop <= ~push;
            r_hi      <= w_rdata;
            r_out     <= '0;
          end else if (flush) begin
            r_out <= '0;
          end else begin
            r_out <= w_bus;
          end
        end
        ST_SECOND: begin
          r_state <= ST_IDLE;
          r_out   <= w_bus;
          if (r_dbl_pop) r_dbl_out <= {r_hi, w_rdata};
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out     = r_out;
  assign dbl_out = r_dbl_out;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; dut_a uses the default stack top, dut_b starts SP at 0.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_res, wdata, wdata_hi, in_port;
  logic [2:0]  rdst;
  logic        mem_read, mem_write, push, pop, dbl, in_sig, wb_en, flush;

  logic        stall_a, stall_b;
  logic [31:0] dbl_out_a, dbl_out_b;
  logic [57:0] out_a, out_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_stage dut_a (
    .clk(clk), .rst(rst), .alu_res(alu_res), .wdata(wdata), .wdata_hi(wdata_hi),
    .rdst(rdst), .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .dbl(dbl), .in_sig(in_sig), .wb_en(wb_en), .in_port(in_port), .flush(flush),
    .stall(stall_a), .dbl_out(dbl_out_a), .out(out_a)
  );

  memory_stage #(.ADDR_W(11), .SP_INIT(0)) dut_b (
    .clk(clk), .rst(rst), .alu_res(alu_res), .wdata(wdata), .wdata_hi(wdata_hi),
    .rdst(rdst), .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
    .dbl(dbl), .in_sig(in_sig), .wb_en(wb_en), .in_port(in_port), .flush(flush),
    .stall(stall_b), .dbl_out(dbl_out_b), .out(out_b)
  );

  // Expected bus: {in_port, mem data, alu_res, rdst, {rd,wr,push,pop,in,dbl,wb}}
  function automatic logic [57:0] bus(input logic [15:0] ip, input logic [15:0] md,
                                      input logic [15:0] alu, input logic [2:0] rd,
                                      input logic [6:0] fl);
    return {ip, md, alu, rd, fl};
  endfunction

  task automatic clr();
    alu_res = '0; wdata = '0; wdata_hi = '0; in_port = '0; rdst = '0;
    mem_read = 0; mem_write = 0; push = 0; pop = 0; dbl = 0; in_sig = 0; wb_en = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a);
    clr(); mem_read = 1; alu_res = a; step();
  endtask

  task automatic do_reset();
    clr(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    clr(); rst = 0; #1 rst = 1; #2;
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out_a); end
    n_checks++; if (dbl_out_a !== 32'd0) begin n_fail++; $display("FAIL reset_dbl_out: got %h want 0", dbl_out_a); end
    n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_a); end
    n_checks++; if (out_b !== 58'd0) begin n_fail++; $display("FAIL reset_out_b: got %h want 0", out_b); end
    step(); rst = 0;
  endtask

  task automatic test_push_pop();
    logic [57:0] e;
    clr(); push = 1; wdata = 16'hABCD; step();
    e = bus(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL push_out: got %h want %h", out_a, e); end
    load(16'h07FF);
    e = bus(16'h0, 16'hABCD, 16'h07FF, 3'd0, 7'b1000000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL push_mem: got %h want %h", out_a, e); end
    clr(); pop = 1; step();
    e = bus(16'h0, 16'hABCD, 16'h0, 3'd0, 7'b0001000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL pop_out: got %h want %h", out_a, e); end
    // SP back at 0x7FF: next push lands there
    clr(); push = 1; wdata = 16'h1111; step();
    load(16'h07FF);
    e = bus(16'h0, 16'h1111, 16'h07FF, 3'd0, 7'b1000000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL pop_sp: got %h want %h", out_a, e); end
    clr(); pop = 1; step();
  endtask

  task automatic test_store_load();
    logic [57:0] e;
    clr(); mem_write = 1; mem_read = 1; alu_res = 16'h0010; wdata = 16'h1234; step();
    e = bus(16'h0, 16'h0, 16'h0010, 3'd0, 7'b0100000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL store_out: got %h want %h", out_a, e); end
    clr(); mem_read = 1; alu_res = 16'h0010; rdst = 3'd5; wb_en = 1; in_sig = 1; in_port = 16'hBEEF; dbl = 1;
    #1;
    n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL dbl_no_stack_stall: got %b want 0", stall_a); end
    step();
    e = bus(16'hBEEF, 16'h1234, 16'h0010, 3'd5, 7'b1000101);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL load_out: got %h want %h", out_a, e); end
  endtask

  task automatic test_double_push();
    logic [57:0] e;
    clr(); push = 1; dbl = 1; wdata_hi = 16'h0001; wdata = 16'h2345; #1;
    n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL dpush_stall1: got %b want 1", stall_a); end
    step();
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL dpush_bubble: got %h want 0", out_a); end
    n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL dpush_stall2: got %b want 0", stall_a); end
    step();
    e = bus(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010010);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL dpush_out: got %h want %h", out_a, e); end
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'h0001) begin n_fail++; $display("FAIL dpush_hi: got %h want 0001", out_a[41:26]); end
    load(16'h07FE);
    n_checks++; if (out_a[41:26] !== 16'h2345) begin n_fail++; $display("FAIL dpush_lo: got %h want 2345", out_a[41:26]); end
  endtask

  task automatic test_double_pop();
    logic [57:0] e;
    // SP=0x7FD: first cycle takes mem[0x7FE] as hi, second takes mem[0x7FF] as lo
    clr(); pop = 1; dbl = 1; #1;
    n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL dpop_stall1: got %b want 1", stall_a); end
    step();
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL dpop_bubble: got %h want 0", out_a); end
    step();
    e = bus(16'h0, 16'h0001, 16'h0, 3'd0, 7'b0001010);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL dpop_out: got %h want %h", out_a, e); end
    n_checks++; if (dbl_out_a !== 32'h2345_0001) begin n_fail++; $display("FAIL dpop_dbl_out: got %h want 23450001", dbl_out_a); end
    clr(); push = 1; wdata = 16'h4242; step();
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'h4242) begin n_fail++; $display("FAIL dpop_sp: got %h want 4242", out_a[41:26]); end
    clr(); pop = 1; step();
  endtask

  task automatic test_flush();
    clr(); mem_write = 1; alu_res = 16'h0020; wdata = 16'h1111; step();
    clr(); mem_write = 1; alu_res = 16'h0020; wdata = 16'h9999; in_port = 16'h5A5A; wb_en = 1; flush = 1; step();
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL flush_out: got %h want 0", out_a); end
    load(16'h0020);
    n_checks++; if (out_a[41:26] !== 16'h1111) begin n_fail++; $display("FAIL flush_mem: got %h want 1111", out_a[41:26]); end
    clr(); push = 1; dbl = 1; wdata_hi = 16'hDEAD; flush = 1; #1;
    n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_a); end
    step();
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL flush_dpush_out: got %h want 0", out_a); end
    // SP must still be 0x7FF
    clr(); push = 1; wdata = 16'h7070; step();
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'h7070) begin n_fail++; $display("FAIL flush_sp: got %h want 7070", out_a[41:26]); end
  endtask

  task automatic test_flush_in_second();
    logic [57:0] e;
    do_reset();
    clr(); push = 1; dbl = 1; wdata_hi = 16'h0A0A; wdata = 16'h0B0B; step();
    flush = 1; step();
    e = bus(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010010);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL second_flush_out: got %h want %h", out_a, e); end
    load(16'h07FE);
    n_checks++; if (out_a[41:26] !== 16'h0B0B) begin n_fail++; $display("FAIL second_flush_lo: got %h want 0B0B", out_a[41:26]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clr(); push = 1; dbl = 1; wdata_hi = 16'hAAAA; wdata = 16'hBBBB; step();
    clr(); rst = 1; #1;
    n_checks++; if (out_a !== 58'd0) begin n_fail++; $display("FAIL rstmid_out: got %h want 0", out_a); end
    n_checks++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall_a); end
    step(); rst = 0;
    // Back in IDLE: a double push request stalls again
    push = 1; dbl = 1; #1;
    n_checks++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got %b want 1", stall_a); end
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'hAAAA) begin n_fail++; $display("FAIL rstmid_partial: got %h want AAAA", out_a[41:26]); end
    clr(); push = 1; wdata = 16'hCCCC; step();
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'hCCCC) begin n_fail++; $display("FAIL rstmid_sp: got %h want CCCC", out_a[41:26]); end
  endtask

  task automatic test_push_pop_together();
    logic [57:0] e;
    do_reset();
    clr(); push = 1; pop = 1; wdata = 16'h3C3C; step();
    e = bus(16'h0, 16'h0, 16'h0, 3'd0, 7'b0010000);
    n_checks++; if (out_a !== e) begin n_fail++; $display("FAIL pushpop_out: got %h want %h", out_a, e); end
    load(16'h07FF);
    n_checks++; if (out_a[41:26] !== 16'h3C3C) begin n_fail++; $display("FAIL pushpop_mem: got %h want 3C3C", out_a[41:26]); end
  endtask

  task automatic test_sp_wrap();
    logic [57:0] e;
    do_reset();
    clr(); push = 1; wdata = 16'h5555; step();
    load(16'h0000);
    e = bus(16'h0, 16'h5555, 16'h0, 3'd0, 7'b1000000);
    n_checks++; if (out_b !== e) begin n_fail++; $display("FAIL wrap_push_mem: got %h want %h", out_b, e); end
    clr(); pop = 1; step();
    e = bus(16'h0, 16'h5555, 16'h0, 3'd0, 7'b0001000);
    n_checks++; if (out_b !== e) begin n_fail++; $display("FAIL wrap_pop: got %h want %h", out_b, e); end
    clr(); push = 1; wdata = 16'h7777; step();
    load(16'h0000);
    n_checks++; if (out_b[41:26] !== 16'h7777) begin n_fail++; $display("FAIL wrap_sp_zero: got %h want 7777", out_b[41:26]); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_store_load();
    test_double_push();
    test_double_pop();
    test_flush();
    test_flush_in_second();
    test_reset_mid();
    test_push_pop_together();
    test_sp_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
